// File: rtl/sqr_seq.sv
// Sequential shift-add squarer: one operand bit per clock, valid/ready on both sides.
// MODE 0 truncates to LEN bits with an overflow flag; MODE 1/2 give the full 2*LEN-bit square.
module sqr_seq #(
  parameter  int LEN   = 16,
  parameter  int MODE  = 0,
  localparam int O_LEN = (MODE == 0) ? LEN : 2 * LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [O_LEN-1:0] Y,
  output logic             ovf
);

  // state  | meaning
  // IDLE   | waiting for an operand, in_ready high
  // BUSY   | LEN shift-add iterations in progress
  // DONE   | result held on Y/ovf until out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_t             state_q, state_d;
  logic [2*LEN-1:0]   acc_q, acc_d;
  logic [2*LEN-1:0]   mul_q, mul_d;
  logic [LEN-1:0]     bit_q, bit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [O_LEN-1:0]   y_q, y_d;
  logic               ovf_q, ovf_d;

  logic               last_iter;
  logic [LEN-1:0]     mag;
  logic [2*LEN-1:0]   acc_sum;

  assign last_iter = (cnt_q == CNT_W'(LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last_iter) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Most negative input negates to itself, which read unsigned is exactly 2^(LEN-1).
  always_comb begin
    mag = X;
    if (MODE == 2 && X[LEN-1]) mag = ~X + LEN'(1);
  end

  // mul_q holds M << i and bit_q holds M >> i, so no barrel shifter is needed.
  assign acc_sum = acc_q + (bit_q[0] ? mul_q : '0);

  always_comb begin
    acc_d = acc_q;
    mul_d = mul_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    y_d   = y_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d = '0;
          mul_d = {{LEN{1'b0}}, mag};
          bit_d = mag;
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        mul_d = mul_q << 1;
        bit_d = bit_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d = '0;
          y_d   = acc_sum[O_LEN-1:0];
          ovf_d = (MODE == 0) && (|acc_sum[2*LEN-1:LEN]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mul_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mul_q <= mul_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign Y   = y_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_sqr_seq.sv
// Directed bench for sqr_seq: one instance per MODE at LEN=16, scoreboard of expected results.
module tb_sqr_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  ovf_v;
  logic [15:0] x_a [3];
  logic [15:0] y0;
  logic [31:0] y1;
  logic [31:0] y2;

  int total;
  int bad;
  logic [32:0] sb_q [$];

  sqr_seq #(.LEN(16), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .X(x_a[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .Y(y0), .ovf(ovf_v[0]));
  sqr_seq #(.LEN(16), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .X(x_a[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .Y(y1), .ovf(ovf_v[1]));
  sqr_seq #(.LEN(16), .MODE(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .X(x_a[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .Y(y2), .ovf(ovf_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] y_of(input int s);
    case (s)
      0:       return {16'h0, y0};
      1:       return y1;
      default: return y2;
    endcase
  endfunction

  // {ovf, Y} reference built from a plain multiply.
  function automatic logic [32:0] model(input int s, input logic [15:0] x);
    longint full;
    if (s == 2) full = longint'($signed(x)) * longint'($signed(x));
    else        full = longint'(x) * longint'(x);
    if (s == 0) return {|full[31:16], 16'h0, full[15:0]};
    return {1'b0, full[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input int s, input string tag);
    logic [32:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_y"}, y_of(s), e[31:0]);
      chk({tag, "_ovf"}, 32'(ovf_v[s]), 32'(e[32]));
    end
  endtask

  // Called right after the accept edge; counts edges until out_valid shows.
  task automatic wait_result(input int s, input string tag);
    int k;
    bit busy_ok;
    k = 0;
    busy_ok = 1'b1;
    while (!out_valid_v[s] && k < 40) begin
      if (in_ready_v[s]) busy_ok = 1'b0;
      step();
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd16);
    chk({tag, "_busy_in_ready"}, 32'(busy_ok), 32'd1);
    pop_check(s, tag);
  endtask

  task automatic do_op(input int s, input logic [15:0] x, input string tag);
    sb_q.push_back(model(s, x));
    out_ready_v[s] = 1'b1;
    in_valid_v[s]  = 1'b1;
    x_a[s]         = x;
    step();
    in_valid_v[s]  = 1'b0;
    x_a[s]         = ~x;
    wait_result(s, tag);
    step();
    chk({tag, "_hs_out_valid"}, 32'(out_valid_v[s]), 32'd0);
    chk({tag, "_hs_in_ready"}, 32'(in_ready_v[s]), 32'd1);
  endtask

  initial begin
    int idx;
    int nres;
    int prev;
    int cyc;
    logic [32:0] e;

    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '1;
    for (int s = 0; s < 3; s++) x_a[s] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_in_ready%0d", s), 32'(in_ready_v[s]), 32'd1);
      chk($sformatf("rst_out_valid%0d", s), 32'(out_valid_v[s]), 32'd0);
      chk($sformatf("rst_y%0d", s), y_of(s), 32'd0);
      chk($sformatf("rst_ovf%0d", s), 32'(ovf_v[s]), 32'd0);
    end
    rst = 1'b0;
    step();

    do_op(0, 16'h0123, "m0_0123");
    do_op(0, 16'h00FF, "m0_00ff");
    do_op(0, 16'hFFFF, "m0_ffff");
    do_op(1, 16'hFFFF, "m1_ffff");
    do_op(2, 16'hFFFF, "m2_neg1");
    do_op(2, 16'h8000, "m2_min");
    do_op(2, 16'h7FFF, "m2_max");
    do_op(2, 16'hFF85, "m2_neg123");

    // Backpressure on MODE 1 with a changing operand offered while DONE.
    sb_q.push_back(model(1, 16'h0ABC));
    out_ready_v[1] = 1'b0;
    in_valid_v[1]  = 1'b1;
    x_a[1]         = 16'h0ABC;
    step();
    in_valid_v[1]  = 1'b0;
    wait_result(1, "bp_first");
    e = model(1, 16'h0ABC);
    in_valid_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_a[1] = 16'h1111 * 16'(i + 1);
      step();
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid_v[1]), 32'd1);
      chk($sformatf("bp_hold_ready%0d", i), 32'(in_ready_v[1]), 32'd0);
      chk($sformatf("bp_hold_y%0d", i), y1, e[31:0]);
    end
    out_ready_v[1] = 1'b1;
    sb_q.push_back(model(1, x_a[1]));
    step();
    chk("bp_release_valid", 32'(out_valid_v[1]), 32'd0);
    chk("bp_release_ready", 32'(in_ready_v[1]), 32'd1);
    chk("bp_release_y_held", y1, e[31:0]);
    step();
    in_valid_v[1] = 1'b0;
    chk("bp_pending_accept", 32'(in_ready_v[1]), 32'd0);
    wait_result(1, "bp_pending");
    step();

    // Reset on the 7th BUSY edge of an in-flight MODE 1 operation.
    in_valid_v[1] = 1'b1;
    x_a[1]        = 16'h1234;
    step();
    in_valid_v[1] = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready_v[1]), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid_v[1]), 32'd0);
    chk("mid_rst_y", y1, 32'd0);
    chk("mid_rst_ovf", 32'(ovf_v[1]), 32'd0);
    chk("mid_rst_y_m0", y_of(0), 32'd0);
    nres = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_v[1]) nres++;
      step();
    end
    chk("mid_rst_no_result", 32'(nres), 32'd0);
    do_op(1, 16'h0003, "after_rst");

    // Back-to-back on MODE 0 with in_valid held high.
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    x_a[0]         = 16'h0;
    idx  = 0;
    nres = 0;
    prev = -1;
    cyc  = 0;
    while (nres < 5 && cyc < 200) begin
      if (out_valid_v[0]) begin
        pop_check(0, $sformatf("b2b_res%0d", nres));
        if (prev >= 0) chk($sformatf("b2b_gap%0d", nres), 32'(cyc - prev), 32'd18);
        prev = cyc;
        nres++;
      end
      if (in_ready_v[0] && idx < 5) begin
        x_a[0] = 16'(idx);
        sb_q.push_back(model(0, 16'(idx)));
        idx++;
      end
      if (nres == 5) in_valid_v[0] = 1'b0;
      else begin
        step();
        cyc++;
      end
    end
    chk("b2b_count", 32'(nres), 32'd5);
    step();
    chk("b2b_idle", 32'(in_ready_v[0]), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqr_seq.md
Name: sqr_seq

Overview:
- Parametrised, multi-cycle squarer: successor to the combinational square block.
- Width and output mode are chosen by parameters, so one module covers truncated, full-unsigned and full-signed squaring.
- Computes one operand bit per clock with a shift-add datapath, trading latency for a much smaller gate count.
- Uses valid/ready handshakes on input and output so it can sit between buffered stages of a generated logic module.

Parameters:
- LEN, 16, operand width in bits (≥2).
- MODE, 0, output mode: 0 = truncated (O_LEN = LEN), 1 = full unsigned (O_LEN = 2*LEN), 2 = full signed (O_LEN = 2*LEN). Any other value is illegal.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand X is valid.
- in_ready  output  1  block accepts an operand this cycle.
- X  input  LEN  operand; two's complement when MODE=2, else unsigned.
- out_valid  output  1  Y and ovf hold a finished result.
- out_ready  input  1  consumer takes the result this cycle.
- Y  output  O_LEN  square of the accepted X, formatted per MODE.
- ovf  output  1  MODE=0 only: high half of the full square is non-zero; always 0 for MODE 1/2.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- After any rst edge: state IDLE, in_ready=1, out_valid=0, Y=0, ovf=0, internal accumulator and counter cleared.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready.
- Accept: on an edge in IDLE with in_valid=1, capture the magnitude M of X, set counter=0 and go to BUSY.
  - MODE=2: M = |X|, LEN bits unsigned. X = -2^(LEN-1) gives M = 2^(LEN-1), no overflow.
  - MODE 0/1: M = X.
- BUSY iteration: each edge adds (M << i) to a 2*LEN-bit accumulator when bit i of M is 1, then increments i.
  - After exactly LEN BUSY edges, go to DONE and load Y and ovf.
  - out_valid is first visible in the cycle after edge accept+LEN. Latency is exactly LEN cycles from accept to out_valid, independent of operand value.
- Result formatting:
  - MODE 1/2: Y = full 2*LEN-bit square. For MODE 2 it is always non-negative.
  - MODE 0: Y = low LEN bits of the full square, identical to X*X truncated and independent of signedness. ovf = OR of the high LEN bits.
- Output handshake: in DONE, an edge with out_ready=1 returns to IDLE and out_valid falls.
  - Y and ovf hold their last value after the handshake; only reset or a new result changes them.
  - While out_ready=0, Y, ovf and out_valid stay stable indefinitely.
- Simultaneous events: in_valid during BUSY/DONE is ignored; the operand is not queued. A new operand is accepted no earlier than the edge after the output handshake, so throughput is one result per LEN+2 cycles minimum.
- Reset mid-operation: rst in BUSY or DONE aborts the computation, discards the result, and applies the reset values above. rst takes priority over every handshake on the same edge.
- X needs to be stable only on the accept edge.

Test Plan:
- LEN=16, MODE=0, X=0x0123, out_ready=1 → after 16 cycles Y=0x4AC9, ovf=1. Then X=0x00FF → Y=0xFE01, ovf=0.
- LEN=16, MODE=1, X=0xFFFF → Y=0xFFFE0001. Check out_valid rises exactly 16 cycles after the accept edge and in_ready=0 throughout.
- LEN=16, MODE=2, X=0xFFFF (-1) → Y=0x00000001. X=0x8000 → Y=0x40000000. X=0x7FFF → Y=0x3FFF0001. ovf=0 in all cases.
- Backpressure, MODE=1: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and X changing → Y, out_valid stable, in_ready=0, no new accept. Raising out_ready → IDLE next cycle, then the pending X is accepted.
- Reset: assert rst for 1 cycle at BUSY iteration 7 → next cycle in_ready=1, out_valid=0, Y=0, ovf=0. A fresh X=3 then yields Y=9 after 16 cycles.
- Back-to-back, MODE=0, in_valid held high with X=0..4 → results 0,1,4,9,16 in order, each spaced 18 cycles apart.
